// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Brief    : Round-robin arbiter sharing the ROB writeback channel (CDB)
//             among NUM_REQ execution units, each buffered by a small FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    _clear,
    input  logic [NUM_REQ-1:0]      _req_valid,
    input  logic [5*NUM_REQ-1:0]    _req_rob_id,
    input  logic [32*NUM_REQ-1:0]   _req_value,
    output logic [NUM_REQ-1:0]      _req_ready,
    output logic                    _cdb_ready,
    output logic [4:0]              _cdb_rob_id,
    output logic [31:0]             _cdb_value,
    output logic                    _drop_err
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_ENT_W = 37;

    // Machine advances only when not paused and not being flushed.
    logic                              w_adv;
    logic [NUM_REQ-1:0]                w_nonempty;
    logic [NUM_REQ-1:0]                w_drop_hit;
    logic [NUM_REQ-1:0][c_ENT_W-1:0]   w_head;
    logic                              w_gnt_vld;
    logic [c_IDX_W-1:0]                w_gnt;
    logic [c_IDX_W-1:0]                r_rr;

    assign w_adv = rdy_in && !_clear;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
            logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
            logic [c_PTR_W-1:0] r_wptr;
            logic [c_PTR_W-1:0] r_rptr;
            logic [c_CNT_W-1:0] r_cnt;
            logic               w_fire;
            logic               w_push;
            logic               w_pop;
            logic [4:0]         w_id;

            assign w_id           = _req_rob_id[5*gi +: 5];
            // Ready comes from the registered count only, never from this cycle's pop.
            assign _req_ready[gi] = (r_cnt < c_CNT_W'(FIFO_DEPTH));
            assign w_fire         = _req_valid[gi] && _req_ready[gi] && w_adv;
            assign w_push         = w_fire && (w_id != 5'd0);
            assign w_drop_hit[gi] = w_fire && (w_id == 5'd0);
            assign w_pop          = w_adv && w_gnt_vld && (w_gnt == c_IDX_W'(gi));
            assign w_nonempty[gi] = (r_cnt != '0);
            assign w_head[gi]     = r_mem[r_rptr];

            // Entry storage: written on push, no reset needed (guarded by count).
            always_ff @(posedge clk_in) begin
                if (w_push) begin
                    r_mem[r_wptr] <= {w_id, _req_value[32*gi +: 32]};
                end
            end

            // Pointer and occupancy bookkeeping with simultaneous push/pop.
            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else if (rdy_in) begin
                    if (_clear) begin
                        r_wptr <= '0;
                        r_rptr <= '0;
                        r_cnt  <= '0;
                    end else begin
                        if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
                        if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
                        case ({w_push, w_pop})
                            2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                            2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                            default: r_cnt <= r_cnt;
                        endcase
                    end
                end
            end
        end
    endgenerate

    // Round-robin search from r_rr over registered occupancy.
    always_comb begin : p_arb
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr) + k) % NUM_REQ;
            if (!w_gnt_vld && w_nonempty[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = c_IDX_W'(idx);
            end
        end
    end

    // Registered broadcast and round-robin pointer update.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_rr        <= '0;
            _cdb_ready  <= 1'b0;
            _cdb_rob_id <= 5'd0;
            _cdb_value  <= 32'd0;
        end else if (rdy_in) begin
            if (_clear) begin
                r_rr       <= '0;
                _cdb_ready <= 1'b0;
            end else if (w_gnt_vld) begin
                _cdb_ready  <= 1'b1;
                _cdb_rob_id <= w_head[w_gnt][36:32];
                _cdb_value  <= w_head[w_gnt][31:0];
                r_rr        <= (w_gnt == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt + c_IDX_W'(1);
            end else begin
                _cdb_ready <= 1'b0;
            end
        end
    end

    // Sticky flag for discarded id-0 requests.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            _drop_err <= 1'b0;
        end else if (|w_drop_hit) begin
            _drop_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
